multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Directly upstream of the Registers block: drives its regWrite, and RegDst/MemtoReg, which select writeRegister/writeData.
- Also sequences PC, IR, memory and ALU control for the supported subset: R-type, lw, sw, beq, j, addi.
- Adds a memory wait-state handshake (memReady) and sticky illegal-opcode detection.

Parameters:
- MEM_WAIT_EN, 1, when 1, FETCH/MEMREAD/MEMWRITE hold until memReady=1; when 0, memReady is ignored and treated as 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instr[31:26] from IR
- memReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  writeData source: 0 = ALUOut, 1 = MDR
- RegDst  output  1  writeRegister source: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable (to Registers.regWrite)
- ALUSrcA  output  1  0 = PC, 1 = regA
- ALUSrcB  output  2  00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = decode funct
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding (debug/verification)
- illegal  output  1  sticky: unsupported opcode decoded

Behaviour:
- Reset (reset=0, asynchronous):
  - state forced to FETCH (0) and illegal cleared.
  - Every output is forced to 0 while reset is low, including FETCH decode. No write enable may pulse during reset.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=12.
  - Codes 13–15 are unreachable; if ever entered, the next state is FETCH.
- Outputs are a pure function of state plus memReady. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=memReady. Advance to DECODE when memReady=1, else stay.
  - DECODE: ALUSrcB=11. Next state by opcode:
    - 000000 → EXECUTE
    - 100011 / 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDIEX
    - any other → ILLEGAL
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Go to MEMREAD if opcode=100011, else MEMWRITE. Opcode is sampled again here; the IR is stable.
  - MEMREAD: MemRead=1, IorD=1. Go to MEMWB on memReady, else stay.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
  - MEMWRITE: MemWrite=1, IorD=1. Go to FETCH on memReady, else stay. MemWrite stays high for every wait cycle.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
  - JUMP: PCWrite=1, PCSource=10 → FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
  - ILLEGAL: illegal set to 1 (sticky until reset); all enables 0. Stay in ILLEGAL (halt).
- Instruction latency with memReady tied high:
  - R-type: 4 cycles; lw: 5; sw: 4; beq: 3; j: 3; addi: 4.
  - Each memory wait cycle adds one cycle.
- RegWrite is high for exactly one cycle per lw / R-type / addi, and never for sw, beq or j.
- Reset asserted mid-instruction aborts immediately: outputs go to 0 asynchronously, and FETCH resumes on the first rising edge after reset is released.
- memReady outside FETCH/MEMREAD/MEMWRITE is ignored.

Test Plan:
- Reset low for 3 cycles with memReady=1 → all outputs 0 and state=0. After release, first cycle shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- opcode=000000, memReady=1 → state sequence 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7.
- opcode=100011, memReady low for 2 cycles in MEMREAD → sequence 0,1,2,3,3,3,4,0. MemRead and IorD held for all three MEMREAD cycles; RegWrite=1, MemtoReg=1 in state 4.
- opcode=101011, then beq (000100), then j (000010) →
  - sw: MemWrite pulses exactly one cycle (memReady=1) and RegWrite stays 0.
  - beq: PCWriteCond=1, ALUOp=01 in state 8.
  - j: PCWrite=1, PCSource=10 in state 9.
- opcode=111111 → state 12, illegal=1, held for 10 cycles with no write enables. Asserting reset clears illegal and returns to state 0.
- Assert reset asynchronously mid-clock during ALUWB → RegWrite drops to 0 before the next edge. After release, the sequence restarts at FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore style).
// Sequences PC, IR, memory, ALU and register-file control for R-type, lw, sw,
// beq, j and addi, with a memory wait-state handshake and a sticky
// illegal-opcode flag.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   opcode      instr[31:26] from the IR
//   memReady    memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
//               datapath controls, decoded from state (and memReady in
//               FETCH), all held at 0 while reset is low
//   state       current state encoding
//   illegal     sticky flag: an unsupported opcode was decoded
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal
);

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11,
    ILLEGAL  = 4'd12
  } stateT;

  stateT stateQ;
  stateT stateNext;
  logic  illegalQ;
  logic  memRdy;

  // Decoded controls before the reset gate.
  logic       pcWriteD;
  logic       pcWriteCondD;
  logic       iorDD;
  logic       memReadD;
  logic       memWriteD;
  logic       irWriteD;
  logic       memtoRegD;
  logic       regDstD;
  logic       regWriteD;
  logic       aluSrcAD;
  logic [1:0] aluSrcBD;
  logic [1:0] aluOpD;
  logic [1:0] pcSourceD;

  // With wait states disabled every memory access completes in one cycle.
  assign memRdy = MEM_WAIT_EN ? memReady : 1'b1;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Sticky illegal flag, set on entry so it is visible in the ILLEGAL cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegalQ <= 1'b0;
    end else if (stateNext == ILLEGAL) begin
      illegalQ <= 1'b1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    stateNext    = stateQ;
    pcWriteD     = 1'b0;
    pcWriteCondD = 1'b0;
    iorDD        = 1'b0;
    memReadD     = 1'b0;
    memWriteD    = 1'b0;
    irWriteD     = 1'b0;
    memtoRegD    = 1'b0;
    regDstD      = 1'b0;
    regWriteD    = 1'b0;
    aluSrcAD     = 1'b0;
    aluSrcBD     = 2'b00;
    aluOpD       = 2'b00;
    pcSourceD    = 2'b00;

    case (stateQ)
      FETCH: begin
        memReadD  = 1'b1;
        aluSrcBD  = 2'b01;
        irWriteD  = memRdy;
        pcWriteD  = memRdy;
        stateNext = memRdy ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcBD = 2'b11;
        case (opcode)
          OP_RTYPE:     stateNext = EXECUTE;
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          OP_ADDI:      stateNext = ADDIEX;
          default:      stateNext = ILLEGAL;
        endcase
      end
      MEMADR: begin
        aluSrcAD  = 1'b1;
        aluSrcBD  = 2'b10;
        stateNext = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memReadD  = 1'b1;
        iorDD     = 1'b1;
        stateNext = memRdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        regWriteD = 1'b1;
        memtoRegD = 1'b1;
        stateNext = FETCH;
      end
      MEMWRITE: begin
        memWriteD = 1'b1;
        iorDD     = 1'b1;
        stateNext = memRdy ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        aluSrcAD  = 1'b1;
        aluOpD    = 2'b10;
        stateNext = ALUWB;
      end
      ALUWB: begin
        regWriteD = 1'b1;
        regDstD   = 1'b1;
        stateNext = FETCH;
      end
      BRANCH: begin
        aluSrcAD     = 1'b1;
        aluOpD       = 2'b01;
        pcWriteCondD = 1'b1;
        pcSourceD    = 2'b01;
        stateNext    = FETCH;
      end
      JUMP: begin
        pcWriteD  = 1'b1;
        pcSourceD = 2'b10;
        stateNext = FETCH;
      end
      ADDIEX: begin
        aluSrcAD  = 1'b1;
        aluSrcBD  = 2'b10;
        stateNext = ADDIWB;
      end
      ADDIWB: begin
        regWriteD = 1'b1;
        stateNext = FETCH;
      end
      ILLEGAL: begin
        stateNext = ILLEGAL;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Reset gates every control so nothing pulses while reset is low,
  // including the FETCH decode the state register sits in during reset.
  assign PCWrite     = reset & pcWriteD;
  assign PCWriteCond = reset & pcWriteCondD;
  assign IorD        = reset & iorDD;
  assign MemRead     = reset & memReadD;
  assign MemWrite    = reset & memWriteD;
  assign IRWrite     = reset & irWriteD;
  assign MemtoReg    = reset & memtoRegD;
  assign RegDst      = reset & regDstD;
  assign RegWrite    = reset & regWriteD;
  assign ALUSrcA     = reset & aluSrcAD;
  assign ALUSrcB     = reset ? aluSrcBD  : 2'b00;
  assign ALUOp       = reset ? aluOpD    : 2'b00;
  assign PCSource    = reset ? pcSourceD : 2'b00;
  assign state       = reset ? STATE_W'(stateQ) : 4'd0;
  assign illegal     = reset & illegalQ;

endmodule
